// File: rtl/energy_accumulator_if.sv
// Sample-in / RAM-write-out bundle for the energy accumulator.
// The slave modport is the accumulator side; the master modport is the producer/RAM side.
interface energy_accumulator_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned IN_WIDTH   = 12
);
  logic                  start;
  logic                  in_valid;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [DATA_WIDTH-1:0] wrData;
  logic                  wrEn;
  logic                  busy;
  logic                  done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wrAddr, wrData, wrEn, busy, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wrAddr, wrData, wrEn, busy, done
  );
endinterface

// File: rtl/energy_accumulator.sv
// Sums squared signed samples over 2^SAMPLE_BITS-sample bins and writes one saturated
// energy word per bin to RAM, for 2^ADDR_WIDTH bins per frame.
module energy_accumulator #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned IN_WIDTH    = 12,
  parameter int unsigned SAMPLE_BITS = 4,
  parameter int unsigned SHIFT       = 16
) (
  input logic               clk,
  input logic               reset,
  energy_accumulator_if.slave bus
);

  localparam int unsigned SqW  = 2 * IN_WIDTH;
  localparam int unsigned AccW = 2 * IN_WIDTH + SAMPLE_BITS;

  typedef enum logic [1:0] {StIdle, StAccum, StWrite, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  bin_q, bin_d;
  logic [SAMPLE_BITS-1:0] smp_q, smp_d;
  logic [AccW-1:0]        acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                   in_ready_q, wr_en_q, busy_q, done_q;

  logic [SqW-1:0]         in_ext, sq;
  logic [AccW-1:0]        acc_sum, acc_shr;
  logic [DATA_WIDTH-1:0]  sat_val;

  // Sign-extend to the product width so the truncated product is the exact square.
  assign in_ext  = {{IN_WIDTH{bus.in_data[IN_WIDTH-1]}}, bus.in_data};
  assign sq      = in_ext * in_ext;
  assign acc_sum = acc_q + AccW'(sq);
  assign acc_shr = acc_sum >> SHIFT;
  assign sat_val = (acc_shr > AccW'({DATA_WIDTH{1'b1}})) ? '1 : acc_shr[DATA_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    smp_d     = smp_q;
    acc_d     = acc_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StAccum;
          bin_d   = '0;
          smp_d   = '0;
          acc_d   = '0;
        end
      end
      StAccum: begin
        if (bus.in_valid) begin
          acc_d = acc_sum;
          smp_d = smp_q + SAMPLE_BITS'(1);
          // Capture the bin result now so wrEn rises the cycle after the last sample.
          if (smp_q == '1) begin
            state_d   = StWrite;
            wr_addr_d = bin_q;
            wr_data_d = sat_val;
          end
        end
      end
      StWrite: begin
        acc_d = '0;
        smp_d = '0;
        if (bin_q == '1) begin
          state_d = StDone;
        end else begin
          bin_d   = bin_q + ADDR_WIDTH'(1);
          state_d = StAccum;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      smp_q      <= '0;
      acc_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      smp_q      <= smp_d;
      acc_q      <= acc_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= (state_d == StAccum);
      wr_en_q    <= (state_d == StWrite);
      busy_q     <= (state_d == StAccum) || (state_d == StWrite);
      done_q     <= (state_d == StDone);
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wrAddr   = wr_addr_q;
  assign bus.wrData   = wr_data_q;
  assign bus.wrEn     = wr_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_energy_accumulator.sv
// Self-checking bench: per-bin energies are predicted from the frame's sample list with
// plain integer arithmetic and compared against the RAM write port.
module tb_energy_accumulator;

  localparam int unsigned DW = 6;
  localparam int unsigned AW = 2;
  localparam int unsigned IW = 4;
  localparam int unsigned SB = 1;
  localparam int unsigned SH = 0;
  localparam int Bins = 1 << AW;
  localparam int Spb  = 1 << SB;
  localparam int NSmp = Bins * Spb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  energy_accumulator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IN_WIDTH(IW)) bus ();

  energy_accumulator #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .IN_WIDTH   (IW),
    .SAMPLE_BITS(SB),
    .SHIFT      (SH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int smp[NSmp];

  always @(negedge clk) begin
    if (bus.wrEn === 1'b1) wr_cnt++;
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Energy of bin b: sum of squares of its samples, shifted, clipped to DW bits.
  function automatic int exp_bin(input int b);
    int s = 0;
    int maxv = (1 << DW) - 1;
    for (int k = 0; k < Spb; k++) s += smp[b*Spb+k] * smp[b*Spb+k];
    s = s >> SH;
    return (s > maxv) ? maxv : s;
  endfunction

  task automatic run_frame(input bit stall, input bit poke, input int abort_bin);
    int  idx = 0, pend = -1, guard = 0, wr0 = wr_cnt, dn0 = done_cnt;
    bit  exp_done = 0, fin = 0, rdy, v;
    check("idle_rdy", bus.in_ready, 0);
    check("idle_busy", bus.busy, 0);
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_busy", bus.busy, 1);
    check("start_rdy", bus.in_ready, 1);
    while (!fin && guard < 200) begin
      if (pend >= 0) begin
        check("wr_en", bus.wrEn, 1);
        check("wr_addr", bus.wrAddr, pend);
        check("wr_data", bus.wrData, exp_bin(pend));
        check("wr_rdy", bus.in_ready, 0);
        check("wr_busy", bus.busy, 1);
        if (pend == abort_bin) begin
          reset        = 1'b1;
          bus.start    = 1'b1;
          bus.in_valid = 1'b1;
          @(posedge clk); #1;
          reset        = 1'b0;
          bus.start    = 1'b0;
          bus.in_valid = 1'b0;
          check("abort_rdy", bus.in_ready, 0);
          check("abort_wren", bus.wrEn, 0);
          check("abort_busy", bus.busy, 0);
          check("abort_done", bus.done, 0);
          check("abort_addr", bus.wrAddr, 0);
          check("abort_data", bus.wrData, 0);
          repeat (4) @(posedge clk);
          #1;
          check("abort_idle", bus.busy, 0);
          check("abort_writes", wr_cnt - wr0, abort_bin + 1);
          check("abort_no_done", done_cnt - dn0, 0);
          return;
        end
        exp_done = (pend == Bins - 1);
        pend = -1;
      end else if (exp_done) begin
        check("done", bus.done, 1);
        check("done_busy", bus.busy, 0);
        fin = 1;
      end else begin
        check("no_wr", bus.wrEn, 0);
      end
      rdy = bus.in_ready;
      v = (idx < NSmp) && (!stall || $urandom_range(1, 0) == 1);
      bus.in_valid = v;
      bus.in_data  = v ? IW'(smp[idx]) : IW'($urandom);
      bus.start    = poke && (fin || $urandom_range(3, 0) == 0);
      @(posedge clk); #1;
      if (v && rdy) begin
        if (idx % Spb == Spb - 1) pend = idx / Spb;
        idx++;
      end
      guard++;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    if (!fin) check("timeout", 0, 1);
    check("frame_writes", wr_cnt - wr0, Bins);
    check("frame_done", done_cnt - dn0, 1);
    if (poke) begin
      check("no_refire_busy", bus.busy, 0);
      check("no_refire_rdy", bus.in_ready, 0);
    end
  endtask

  task automatic rand_samples();
    for (int i = 0; i < NSmp; i++) smp[i] = int'($urandom_range(15, 0)) - 8;
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", bus.in_ready, 0);
    check("rst_wren", bus.wrEn, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_addr", bus.wrAddr, 0);
    check("rst_data", bus.wrData, 0);
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", bus.busy, 0);

    smp = '{3, -4, 1, 1, 0, 0, 2, -2};
    run_frame(0, 0, -1);

    smp = '{-8, -8, 7, 3, -8, 7, -1, 0};
    run_frame(0, 0, -1);

    rand_samples();
    run_frame(1, 0, -1);
    rand_samples();
    run_frame(1, 0, -1);

    rand_samples();
    run_frame(1, 1, -1);

    smp = '{3, -4, 1, 1, 0, 0, 2, -2};
    run_frame(0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    run_frame(0, 0, -1);

    rand_samples();
    run_frame(0, 0, -1);
    run_frame(0, 0, -1);

    for (int f = 0; f < 4; f++) begin
      rand_samples();
      run_frame(f[0], f[1], -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
